// File: rtl/mul4_vector_scorer.sv
// rtl/mul4_vector_scorer.sv - exhaustive stimulus driver and bit-match scorer for 2x2 multiplier individuals
module mul4_vector_scorer #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic [15:0] a1,
  output logic [15:0] a0,
  output logic [15:0] b1,
  output logic [15:0] b0,
  input  logic [15:0] y3,
  input  logic [15:0] y2,
  input  logic [15:0] y1,
  input  logic [15:0] y0,
  output logic        score_valid,
  input  logic        score_ready,
  output logic [6:0]  score,
  output logic [15:0] lane_pass,
  output logic        perfect
);

  // Lane i carries A = i[3:2], B = i[1:0]; E* are the true product bits per lane.
  localparam logic [15:0] STIM_A1 = 16'hFF00;
  localparam logic [15:0] STIM_A0 = 16'hF0F0;
  localparam logic [15:0] STIM_B1 = 16'hCCCC;
  localparam logic [15:0] STIM_B0 = 16'hAAAA;
  localparam logic [15:0] EXP_Y3  = 16'h8000;
  localparam logic [15:0] EXP_Y2  = 16'h4C00;
  localparam logic [15:0] EXP_Y1  = 16'h6AC0;
  localparam logic [15:0] EXP_Y0  = 16'hA0A0;

  typedef enum logic [1:0] {IDLE, DRIVE, SCORE, HOLD} state_t;

  state_t      state;
  logic [3:0]  settle_cnt;
  logic [3:0]  lane;
  logic [6:0]  acc;
  logic [15:0] pass_acc;
  logic [15:0] cap3, cap2, cap1, cap0;

  logic [3:0]  lane_diff;
  logic [2:0]  lane_match;
  logic [6:0]  acc_next;
  logic        lane_ok;

  // Compare the current lane of the captured response against the true product.
  always_comb begin
    lane_diff  = {cap3[lane], cap2[lane], cap1[lane], cap0[lane]}
               ^ {EXP_Y3[lane], EXP_Y2[lane], EXP_Y1[lane], EXP_Y0[lane]};
    lane_match = 3'd4 - ({2'b00, lane_diff[3]} + {2'b00, lane_diff[2]}
                       + {2'b00, lane_diff[1]} + {2'b00, lane_diff[0]});
    acc_next   = acc + {4'd0, lane_match};
    lane_ok    = (lane_diff == 4'd0);
  end

  // Evaluation sequencer: drive stimulus, capture once settled, score lane by lane, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= 4'd0;
      lane        <= 4'd0;
      acc         <= 7'd0;
      pass_acc    <= 16'd0;
      cap3        <= 16'd0;
      cap2        <= 16'd0;
      cap1        <= 16'd0;
      cap0        <= 16'd0;
      busy        <= 1'b0;
      a1          <= 16'd0;
      a0          <= 16'd0;
      b1          <= 16'd0;
      b0          <= 16'd0;
      score_valid <= 1'b0;
      score       <= 7'd0;
      lane_pass   <= 16'd0;
      perfect     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= DRIVE;
            settle_cnt <= 4'(SETTLE - 1);
            busy       <= 1'b1;
            a1         <= STIM_A1;
            a0         <= STIM_A0;
            b1         <= STIM_B1;
            b0         <= STIM_B0;
          end
        end
        DRIVE: begin
          if (settle_cnt == 4'd0) begin
            cap3     <= y3;
            cap2     <= y2;
            cap1     <= y1;
            cap0     <= y0;
            lane     <= 4'd0;
            acc      <= 7'd0;
            pass_acc <= 16'd0;
            state    <= SCORE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SCORE: begin
          acc            <= acc_next;
          pass_acc[lane] <= lane_ok;
          lane           <= lane + 4'd1;
          if (lane == 4'd15) begin
            state       <= HOLD;
            score       <= acc_next;
            lane_pass   <= {lane_ok, pass_acc[14:0]};
            perfect     <= (acc_next == 7'd64);
            score_valid <= 1'b1;
            a1          <= 16'd0;
            a0          <= 16'd0;
            b1          <= 16'd0;
            b0          <= 16'd0;
          end
        end
        HOLD: begin
          if (score_ready) begin
            score_valid <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_vector_scorer.sv
// tb/tb_mul4_vector_scorer.sv - self-checking bench for mul4_vector_scorer
module tb_mul4_vector_scorer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic        ready1 = 1'b0, ready4 = 1'b0;
  logic [15:0] y3_1 = 16'd0, y2_1 = 16'd0, y1_1 = 16'd0, y0_1 = 16'd0;
  logic [15:0] y3_4 = 16'd0, y2_4 = 16'd0, y1_4 = 16'd0, y0_4 = 16'd0;
  logic        busy1, sv1, perf1, busy4, sv4, perf4;
  logic [15:0] a1_1, a0_1, b1_1, b0_1, lp1;
  logic [15:0] a1_4, a0_4, b1_4, b0_4, lp4;
  logic [6:0]  sc1, sc4;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  mul4_vector_scorer #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1),
    .a1(a1_1), .a0(a0_1), .b1(b1_1), .b0(b0_1),
    .y3(y3_1), .y2(y2_1), .y1(y1_1), .y0(y0_1),
    .score_valid(sv1), .score_ready(ready1), .score(sc1),
    .lane_pass(lp1), .perfect(perf1)
  );

  mul4_vector_scorer #(.SETTLE(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4),
    .a1(a1_4), .a0(a0_4), .b1(b1_4), .b0(b0_4),
    .y3(y3_4), .y2(y2_4), .y1(y1_4), .y0(y0_4),
    .score_valid(sv4), .score_ready(ready4), .score(sc4),
    .lane_pass(lp4), .perfect(perf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Score from first principles: lane i must show the product (i>>2)*(i&3).
  function automatic void model_score(input logic [15:0] r3, r2, r1, r0,
                                      output int sc, output logic [15:0] lp);
    int p, m;
    logic [3:0] got;
    sc = 0;
    lp = 16'd0;
    for (int i = 0; i < 16; i++) begin
      p = (i >> 2) * (i & 3);
      got = {r3[i], r2[i], r1[i], r0[i]};
      m = 0;
      for (int b = 0; b < 4; b++) if (got[b] == p[b]) m++;
      sc += m;
      lp[i] = (m == 4);
    end
  endfunction

  // Timeline model of the SETTLE=1 instance, counted in cycles since start was taken.
  int          m_t = -1;
  logic        m_valid = 1'b0;
  int          m_score = 0;
  logic [15:0] m_pass = 16'd0;
  logic        m_perf = 1'b0;
  int          c_sc = 0;
  logic [15:0] c_lp = 16'd0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_t = -1; m_valid = 1'b0; m_score = 0; m_pass = 16'd0; m_perf = 1'b0;
    end else if (m_valid) begin
      if (ready1) begin m_valid = 1'b0; m_t = -1; end
    end else if (m_t < 0) begin
      if (start1) m_t = 0;
    end else begin
      m_t++;
      if (m_t == 1) model_score(y3_1, y2_1, y1_1, y0_1, c_sc, c_lp);
      if (m_t == 17) begin
        m_valid = 1'b1; m_score = c_sc; m_pass = c_lp; m_perf = (c_sc == 64);
      end
    end
  end

  // Every-cycle comparison of the SETTLE=1 instance against the model.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("busy", busy1, (m_t >= 0));
      chk("score_valid", sv1, m_valid);
      chk("score", sc1, m_score);
      chk("lane_pass", lp1, m_pass);
      chk("perfect", perf1, m_perf);
      chk("stimulus", {a1_1, a0_1, b1_1, b0_1},
          (m_t >= 0 && !m_valid) ? 64'hFF00_F0F0_CCCC_AAAA : 64'd0);
    end
  end

  task automatic run1(input logic [15:0] v3, v2, v1, v0, input logic [6:0] es,
                      input logic [15:0] ep, input logic eperf, input int holdc,
                      input string tag);
    int n;
    y3_1 = v3; y2_1 = v2; y1_1 = v1; y0_1 = v0;
    ready1 = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; n = 1;
    while (!sv1 && n < 100) begin
      if (n == 4) begin
        y3_1 = 16'($urandom); y2_1 = 16'($urandom); y1_1 = 16'($urandom); y0_1 = 16'($urandom);
      end
      @(negedge clk); n++;
    end
    chk({tag, " latency"}, n, 18);
    chk({tag, " score lit"}, sc1, es);
    chk({tag, " lane_pass lit"}, lp1, ep);
    chk({tag, " perfect lit"}, perf1, eperf);
    for (int i = 0; i < holdc; i++) begin
      start1 = (i % 3 == 0);
      @(negedge clk);
      chk({tag, " hold busy"}, busy1, 1'b1);
      chk({tag, " hold valid"}, sv1, 1'b1);
      chk({tag, " hold score"}, sc1, es);
      chk({tag, " hold lane_pass"}, lp1, ep);
    end
    ready1 = 1'b1; start1 = 1'b1;
    @(negedge clk); ready1 = 1'b0; start1 = 1'b0;
    chk({tag, " after xfer valid"}, sv1, 1'b0);
    chk({tag, " after xfer busy"}, busy1, 1'b0);
    chk({tag, " retained score"}, sc1, es);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
    chk("reset busy", busy1, 1'b0);
    chk("reset score", sc1, 7'd0);
    chk("reset u4", {busy4, sv4, sc4, lp4, perf4}, 26'd0);
    chk("reset u4 stim", {a1_4, a0_4, b1_4, b0_4}, 64'd0);

    run1(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 7'd64, 16'hFFFF, 1'b1, 0, "correct");
    run1(16'h0000, 16'h0000, 16'h0000, 16'h0000, 7'd50, 16'h111F, 1'b0, 0, "zeros");
    run1(16'h7FFF, 16'h4C00, 16'h6AC0, 16'hA0A0, 7'd48, 16'h0000, 1'b0, 0, "y3inv");
    run1(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 7'd64, 16'hFFFF, 1'b1, 10, "backpressure");

    // SETTLE=4: only the 4th DRIVE cycle carries the correct response.
    y3_4 = ~16'h8000; y2_4 = ~16'h4C00; y1_4 = ~16'h6AC0; y0_4 = ~16'hA0A0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; n = 1;
    while (!sv4 && n < 100) begin
      if (n == 4) begin y3_4 = 16'h8000; y2_4 = 16'h4C00; y1_4 = 16'h6AC0; y0_4 = 16'hA0A0; end
      if (n == 5) begin y3_4 = 16'h1234; y2_4 = 16'h5678; y1_4 = 16'h9ABC; y0_4 = 16'hDEF0; end
      @(negedge clk); n++;
    end
    chk("settle4 latency", n, 21);
    chk("settle4 score", sc4, 7'd64);
    chk("settle4 lane_pass", lp4, 16'hFFFF);
    chk("settle4 perfect", perf4, 1'b1);
    ready4 = 1'b1;
    @(negedge clk); ready4 = 1'b0;
    chk("settle4 after xfer", {busy4, sv4}, 2'b00);

    // Reset during the 8th SCORE cycle.
    y3_1 = 16'h8000; y2_1 = 16'h4C00; y1_1 = 16'h6AC0; y0_1 = 16'hA0A0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; n = 1;
    while (n < 9) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst busy", busy1, 1'b0);
    chk("midrst valid", sv1, 1'b0);
    chk("midrst score", sc1, 7'd0);
    chk("midrst stim", {a1_1, a0_1, b1_1, b0_1}, 64'd0);
    run1(16'h8000, 16'h4C00, 16'h6AC0, 16'hA0A0, 7'd64, 16'hFFFF, 1'b1, 0, "after rst");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
